// File: rtl/grn_sweeper_if.sv
// Command and result handshake bundle between a sweep controller and its client.
// The sweeper uses the slave modport; the client side uses master.
interface grn_sweeper_if #(
  parameter int unsigned SIZE = 69
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SIZE-1:0] cmd_base;
  logic [31:0]     cmd_count;

  logic            res_valid;
  logic            res_ready;
  logic [SIZE-1:0] res_conf;
  logic [31:0]     res_length;
  logic [31:0]     res_transient;
  logic            res_last;

  modport master (
    output cmd_valid, cmd_base, cmd_count,
    input  cmd_ready,
    input  res_valid, res_conf, res_length, res_transient, res_last,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_count,
    output cmd_ready,
    output res_valid, res_conf, res_length, res_transient, res_last,
    input  res_ready
  );
endinterface

// File: rtl/grn_sweeper.sv
// Sweeps a range of configurations through an attractor core and queues the results.
// Optional max-length statistics are enabled by defining GRN_SWEEP_STATS_EN.
module grn_sweeper #(
  parameter int unsigned SIZE       = 69,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  grn_sweeper_if.slave    bus,
  output logic            grn_start_out,
  output logic [SIZE-1:0] grn_conf_out,
  input  logic            grn_done_in,
  input  logic [31:0]     grn_length_in,
  input  logic [31:0]     grn_transient_in,
  output logic            grn_ack_out,
  output logic            busy
`ifdef GRN_SWEEP_STATS_EN
  ,
  output logic [31:0]     stat_max_length,
  output logic [SIZE-1:0] stat_max_conf
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = SIZE + 65;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_GUARD   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [SIZE-1:0] cur_conf_q, cur_conf_d;
  logic [31:0]     remaining_q, remaining_d;
  logic            guard_q, guard_d;
  logic            start_q, start_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            rdy_q, rdy_d;

  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [EW-1:0]   mem [FIFO_DEPTH];

  logic            accept_c, push_c, pop_c, full_c, empty_c;

  assign full_c   = (cnt_q == CW'(FIFO_DEPTH));
  assign empty_c  = (cnt_q == '0);
  assign accept_c = bus.cmd_valid && rdy_q;
  assign push_c   = (state_q == S_WAIT) && grn_done_in && !full_c;
  assign pop_c    = !empty_c && bus.res_ready;

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    cur_conf_d  = cur_conf_q;
    remaining_d = remaining_q;
    guard_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c && (bus.cmd_count != 32'd0)) begin
          cur_conf_d  = bus.cmd_base;
          remaining_d = bus.cmd_count;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (push_c) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        cur_conf_d  = cur_conf_q + SIZE'(1);
        remaining_d = remaining_q - 32'd1;
        state_d     = S_GUARD;
      end
      S_GUARD: begin
        // two cycles so the core settles back to its init state
        guard_d = !guard_q;
        if (guard_q) state_d = (remaining_q != 32'd0) ? S_LAUNCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_LAUNCH);
    ack_d   = (state_d == S_CAPTURE);
    busy_d  = (state_d != S_IDLE);
    rdy_d   = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_conf_q  <= '0;
      remaining_q <= '0;
      guard_q     <= 1'b0;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_conf_q  <= cur_conf_d;
      remaining_q <= remaining_d;
      guard_q     <= guard_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      rdy_q       <= rdy_d;
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= {cur_conf_q, grn_length_in, grn_transient_in, (remaining_q == 32'd1)};
    end
  end

  assign {bus.res_conf, bus.res_length, bus.res_transient, bus.res_last} = mem[rd_ptr_q];
  assign bus.res_valid = !empty_c;
  assign bus.cmd_ready = rdy_q;
  assign grn_start_out = start_q;
  assign grn_ack_out   = ack_q;
  assign grn_conf_out  = cur_conf_q;
  assign busy          = busy_q;

`ifdef GRN_SWEEP_STATS_EN
  logic [31:0]     max_len_q;
  logic [SIZE-1:0] max_conf_q;

  // Running maximum over the current sweep; strictly-greater keeps the first conf on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_len_q  <= '0;
      max_conf_q <= '0;
    end else if (accept_c) begin
      max_len_q  <= '0;
      max_conf_q <= '0;
    end else if (push_c && (grn_length_in > max_len_q)) begin
      max_len_q  <= grn_length_in;
      max_conf_q <= cur_conf_q;
    end
  end

  assign stat_max_length = max_len_q;
  assign stat_max_conf   = max_conf_q;
`endif

endmodule

// File: tb/tb_grn_sweeper.sv
// Scoreboard bench for grn_sweeper with a behavioural attractor-core model.
module tb_grn_sweeper;
  localparam int unsigned SIZE  = 69;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  grn_sweeper_if #(.SIZE(SIZE)) bus();

  logic            grn_start_out, grn_ack_out, busy;
  logic [SIZE-1:0] grn_conf_out;
  logic            grn_done_in = 1'b0;
  logic [31:0]     grn_length_in = '0;
  logic [31:0]     grn_transient_in = '0;
`ifdef GRN_SWEEP_STATS_EN
  logic [31:0]     stat_max_length;
  logic [SIZE-1:0] stat_max_conf;
`endif

  grn_sweeper #(.SIZE(SIZE), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .grn_start_out    (grn_start_out),
    .grn_conf_out     (grn_conf_out),
    .grn_done_in      (grn_done_in),
    .grn_length_in    (grn_length_in),
    .grn_transient_in (grn_transient_in),
    .grn_ack_out      (grn_ack_out),
    .busy             (busy)
`ifdef GRN_SWEEP_STATS_EN
    ,
    .stat_max_length  (stat_max_length),
    .stat_max_conf    (stat_max_conf)
`endif
  );

  typedef struct packed {
    logic [SIZE-1:0] conf;
    logic [31:0]     len;
    logic [31:0]     tr;
    logic            last;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cnt = 0;
  int          ack_cnt = 0;
  int          rise_cyc = -1;
  bit          lat_chk = 1'b0;
  logic        done_prev = 1'b0;
  int          core_lat = 2;
  int          launch_idx = 0;
  logic [31:0] len_tab [8];
  bit          pending = 1'b0;
  bit          drop_next = 1'b0;
  int          dly = 0;

  always @(posedge clk) cyc++;

  // Core model: done rises core_lat cycles after a start, drops the cycle after ack
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      grn_done_in = 1'b0;
      pending     = 1'b0;
      drop_next   = 1'b0;
    end else begin
      if (drop_next) begin
        grn_done_in = 1'b0;
        drop_next   = 1'b0;
      end
      if (grn_ack_out) drop_next = 1'b1;
      if (grn_start_out) begin
        pending = 1'b1;
        dly     = core_lat;
      end else if (pending) begin
        if (dly <= 1) begin
          grn_done_in      = 1'b1;
          grn_length_in    = len_tab[launch_idx % 8];
          grn_transient_in = 32'd7;
          launch_idx++;
          pending = 1'b0;
        end else begin
          dly--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every result handshake and watches pulses
  always @(negedge clk) begin
    exp_t got, exp;
    if (rst_n) begin
      if (bus.res_valid && bus.res_ready) begin
        got = {bus.res_conf, bus.res_length, bus.res_transient, bus.res_last};
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_entry got=%h", got);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL entry got=%h exp=%h", got, exp);
          end
        end
      end
      if (grn_start_out) start_cnt++;
      if (grn_ack_out) ack_cnt++;
      if (grn_start_out && grn_ack_out) begin
        checks++;
        errors++;
        $display("FAIL start_ack_overlap got=11 exp=not both");
      end
      if (grn_done_in && !done_prev) rise_cyc = cyc;
      if (grn_start_out) begin
        if (lat_chk && rise_cyc >= 0) begin
          checks++;
          if (cyc - rise_cyc != 4) begin
            errors++;
            $display("FAIL done_to_start_latency got=%0d exp=4", cyc - rise_cyc);
          end
        end
        rise_cyc = -1;
      end
      if (!busy) rise_cyc = -1;
      done_prev = grn_done_in;
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [SIZE-1:0] base, input logic [31:0] count);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = base;
    bus.cmd_count = count;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout got=0 exp=1");
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_sweep(input logic [SIZE-1:0] base, input int count);
    for (int i = 0; i < count; i++)
      sb_q.push_back('{conf: base + SIZE'(i), len: len_tab[i % 8], tr: 32'd7, last: (i == count - 1)});
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout got=busy/pending exp=idle", name);
    end
  endtask

  task automatic wait_count(input string name, input bit use_ack, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if ((use_ack ? ack_cnt : start_cnt) >= n) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=%0d exp=%0d", name, use_ack ? ack_cnt : start_cnt, n);
    end
  endtask

  task automatic new_test();
    start_cnt  = 0;
    ack_cnt    = 0;
    launch_idx = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_busy, any_valid;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_count = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) len_tab[i] = 32'd2;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 128'(bus.cmd_ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_res_valid", 128'(bus.res_valid), 128'd0);
    check("rst_pulses", 128'({grn_start_out, grn_ack_out}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_release", 128'(bus.cmd_ready), 128'd1);

    // Basic sweep base=5 count=3, plus a command ignored while busy
    new_test();
    lat_chk = 1'b1;
    expect_sweep(SIZE'(5), 3);
    send_cmd(SIZE'(5), 32'd3);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = SIZE'(99);
    bus.cmd_count = 32'd1;
    repeat (3) begin
      @(negedge clk);
      check("busy_cmd_ready", 128'({bus.cmd_ready, busy}), 128'b01);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_idle("basic");
    lat_chk = 1'b0;
    check("basic_starts", 128'(start_cnt), 128'd3);
    check("basic_acks", 128'(ack_cnt), 128'd3);
    check("basic_sb_empty", 128'(sb_q.size()), 128'd0);

    // Zero-count command does nothing
    new_test();
    any_busy  = 1'b0;
    any_valid = 1'b0;
    send_cmd(SIZE'(9), 32'd0);
    repeat (8) begin
      @(negedge clk);
      any_busy  |= busy;
      any_valid |= bus.res_valid;
    end
    check("zero_busy", 128'(any_busy), 128'd0);
    check("zero_res_valid", 128'(any_valid), 128'd0);
    check("zero_starts", 128'(start_cnt), 128'd0);

    // Wrap of the configuration counter
    new_test();
    expect_sweep('1, 2);
    send_cmd('1, 32'd2);
    wait_idle("wrap");
    check("wrap_starts", 128'(start_cnt), 128'd2);

    // Back-pressure: FIFO fills, fifth done held unacknowledged
    new_test();
    bus.res_ready = 1'b0;
    expect_sweep(SIZE'(100), 6);
    send_cmd(SIZE'(100), 32'd6);
    wait_count("bp_fill", 1'b1, 4);
    repeat (12) @(negedge clk);
    check("bp_acks_held", 128'(ack_cnt), 128'd4);
    check("bp_starts_held", 128'(start_cnt), 128'd5);
    check("bp_done_held", 128'({grn_done_in, busy, bus.res_valid}), 128'b111);
    check("bp_queue_intact", 128'(sb_q.size()), 128'd6);
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    wait_idle("bp");
    check("bp_acks", 128'(ack_cnt), 128'd6);
    check("bp_starts", 128'(start_cnt), 128'd6);

    // Asynchronous reset while waiting on the core
    new_test();
    bus.res_ready = 1'b0;
    core_lat      = 6;
    send_cmd(SIZE'(10), 32'd3);
    wait_count("rst_first_ack", 1'b1, 1);
    wait_count("rst_second_start", 1'b0, 2);
    repeat (2) @(negedge clk);
    check("pre_rst_res_valid", 128'({bus.res_valid, busy}), 128'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 128'({bus.res_valid, busy, bus.cmd_ready, grn_start_out, grn_ack_out}), 128'd0);
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    bus.res_ready = 1'b1;
    core_lat      = 2;
    @(negedge clk);
    check("post_rst_cmd_ready", 128'({bus.cmd_ready, bus.res_valid}), 128'b10);
    new_test();
    expect_sweep(SIZE'(20), 1);
    send_cmd(SIZE'(20), 32'd1);
    wait_idle("post_rst");
    check("post_rst_starts", 128'(start_cnt), 128'd1);

`ifdef GRN_SWEEP_STATS_EN
    // Statistics: ties do not replace the earlier maximum
    new_test();
    len_tab[0] = 32'd3;
    len_tab[1] = 32'd9;
    len_tab[2] = 32'd9;
    expect_sweep(SIZE'(0), 3);
    send_cmd(SIZE'(0), 32'd3);
    wait_idle("stats");
    check("stat_max_length", 128'(stat_max_length), 128'd9);
    check("stat_max_conf", 128'(stat_max_conf), 128'd1);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grn_sweeper.md
GRN_SWEEPER -- requirements
Module: grn_sweeper

Interface
REQ-001 Parameter SIZE, default 69: configuration vector width; SHALL match the attractor core.
REQ-002 Parameter FIFO_DEPTH, default 4: result FIFO entries, power of two, at least 2.
REQ-003 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 cmd_valid  in  1  sweep request.
REQ-006 cmd_ready  out  1  high in IDLE only; the command is accepted on cmd_valid&&cmd_ready.
REQ-007 cmd_base  in  SIZE  first configuration.
REQ-008 cmd_count  in  32  number of configurations to evaluate.
REQ-009 grn_start_out  out  1  one-cycle start pulse to the core's start_in.
REQ-010 grn_conf_out  out  SIZE  configuration to the core's conf_in; SHALL be stable while grn_start_out=1.
REQ-011 grn_done_in  in  1  the core's done_out, level held until acknowledged.
REQ-012 grn_length_in, grn_transient_in  in  32 each  the core's length_out and transient_out; valid while grn_done_in=1.
REQ-013 grn_ack_out  out  1  one-cycle acknowledge pulse to the core's done_in.
REQ-014 res_valid  out  1  FIFO not empty; res_ready  in  1; an entry pops on res_valid&&res_ready.
REQ-015 res_conf (SIZE), res_length (32), res_transient (32), res_last (1)  out  head entry; res_last marks the final configuration of a sweep.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, LAUNCH, WAIT, CAPTURE and GUARD.
REQ-018 IDLE: on command accept with cmd_count>0, latch cur_conf=cmd_base and remaining=cmd_count, then go to LAUNCH.
REQ-019 IDLE: on command accept with cmd_count=0, stay in IDLE; no start pulse and no result entry.
REQ-020 LAUNCH: grn_start_out=1 for exactly one cycle with grn_conf_out=cur_conf, then go to WAIT.
REQ-021 WAIT: when grn_done_in=1 and the FIFO is not full, push {cur_conf, grn_length_in, grn_transient_in, remaining==1} and go to CAPTURE.
REQ-022 WAIT with the FIFO full: hold in WAIT and do not acknowledge; the core holds done_out, so no data SHALL be lost.
REQ-023 CAPTURE: grn_ack_out=1 for one cycle; cur_conf increments modulo 2^SIZE (wrap from all-ones to 0) and remaining decrements; go to GUARD.
REQ-024 GUARD: last exactly 2 cycles, so the core can reach its init state; then go to LAUNCH if remaining>0, else IDLE.
REQ-025 Latency: from the sampled grn_done_in rise, the next grn_start_out SHALL assert 4 cycles later (FIFO not full).
REQ-026 grn_start_out and grn_ack_out SHALL never be high in the same cycle.
REQ-027 FIFO: simultaneous push and pop when full is not allowed (push is gated by full); push and pop in the same cycle when non-empty keep the occupancy unchanged.
REQ-028 cmd_valid while busy SHALL be ignored (not accepted, cmd_ready=0).

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, FIFO empty, cur_conf=0, remaining=0.
REQ-030 Output values while reset is asserted: all pulses low, res_valid=0, busy=0, cmd_ready=0; cmd_ready=1 from the first clock after release.
REQ-031 Reset during a sweep SHALL abort it with no flush; the system SHALL reset the core concurrently.

Configuration
REQ-032 Macro GRN_SWEEP_STATS_EN.
REQ-033 When GRN_SWEEP_STATS_EN is defined: add outputs stat_max_length (32) and stat_max_conf (SIZE).
REQ-034 Statistics update: both stats clear to 0 on command accept; on each push, if grn_length_in > stat_max_length (strictly greater), both stats SHALL update.
REQ-035 When GRN_SWEEP_STATS_EN is undefined: the stat ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 base=5, count=3, core model returns length=2 and transient=7 -> 3 entries with confs 5, 6, 7; res_last only on 7; 3 start pulses and 3 ack pulses.
REQ-037 count=0 -> no start pulse, busy stays 0, res_valid stays 0.
REQ-038 base=all-ones, count=2 -> confs all-ones then 0.
REQ-039 res_ready=0, count=6, FIFO_DEPTH=4 -> 4 entries queued; the 5th done is held unacknowledged; after draining, all 6 entries arrive in order.
REQ-040 rst_n low while in WAIT -> asynchronous clear, res_valid=0; next command starts cleanly.
REQ-041 STATS_EN build, lengths 3, 9, 9 for confs 0, 1, 2 -> stat_max_length=9, stat_max_conf=1.
